uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Byte-wide UART transmitter driving the SOC TXD pin (currently tied low).
//  Consumes bytes from SOC logic (e.g. LED count snapshots) over a valid/ready handshake.
//  Serialises each byte as 8N1 (8O1/8E1 optional), LSB first, at a fixed baud rate.
//  Runs on the internal clk/resetn pair that Clockworks produces.
// PARAMETERS
//  CLK_FREQ_HZ  12000000  frequency of clk in Hz
//  BAUD         9600      line rate in bit/s
//  PARITY_ODD   0         parity sense when UART_TX_PARITY_EN is defined; 0 = even, 1 = odd
//  DIV (localparam)       (CLK_FREQ_HZ + BAUD/2) / BAUD, clk cycles per bit; must be >= 2
// PORTS
//  clk       in   1  system clock; all logic on posedge
//  resetn    in   1  synchronous reset, active low
//  tx_data   in   8  byte to send; sampled only on an accept cycle
//  tx_valid  in   1  producer has a byte
//  tx_ready  out  1  transmitter idle and can accept
//  tx_busy   out  1  frame in progress
//  txd       out  1  serial line, idle high; connects to SOC TXD
// BEHAVIOUR
//  - All outputs are registered. When resetn is low at a clk edge: txd=1, tx_ready=1, tx_busy=0, state=IDLE, counters=0.
//  - Accept: tx_valid & tx_ready at a posedge. tx_data is latched into a shift register, tx_ready goes 0, tx_busy goes 1, and txd goes 0 (start bit) on that same edge.
//  - FSM: IDLE -> START -> DATA (8 bits, bit index 0..7) -> [PARITY] -> STOP -> IDLE.
//  - Each of START, every DATA bit, PARITY and STOP holds txd for exactly DIV clk cycles.
//  - Baud counter counts 0..DIV-1. It restarts at 0 on accept and on every bit transition. Width is $clog2(DIV).
//  - DATA drives shreg[0] and shifts right once per bit. STOP drives 1.
//  - After the last STOP cycle the FSM returns to IDLE with tx_ready=1 and tx_busy=0. Consecutive frames are therefore separated by exactly one idle clk cycle (txd=1).
//  - Frame latency: accept edge to the end of stop = 10*DIV cycles (11*DIV with parity).
//  - tx_valid while busy is ignored, with no queueing. tx_data changes mid-frame do not affect the frame.
//  - Reset mid-frame: the next edge with resetn low aborts the frame. txd returns to 1 immediately, and tx_ready=1 on the first cycle after resetn rises.
//  - tx_ready is never 1 while tx_busy is 1.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP.
//    It drives ^latched_byte ^ PARITY_ODD. The frame is 11 bits.
//  UART_TX_PARITY_EN undefined: no PARITY state and no parity logic are generated. The frame is 10 bits (8N1).
// STRUCTURE
//  Shared package uart_pkg holds:
//    - state typedef: IDLE, START, DATA, PARITY, STOP
//    - UART_DATA_W=8
//    - UART_IDLE_LVL=1'b1
//    - DIV computation function
//    A future uart_rx reuses this package.
//  One sub-module, uart_baud_gen, holds the DIV counter. Ports: clk, resetn, restart, tick (1-cycle pulse at count DIV-1).
//  uart_tx contains the FSM, shift register, bit index and parity.
// TESTING (bench uses CLK_FREQ_HZ=16, BAUD=4 -> DIV=4)
//  1. Reset: hold resetn=0 for 3 clk -> txd=1, tx_ready=1, tx_busy=0. Release -> outputs unchanged.
//  2. Single byte, no parity: tx_data=0x55, 1-cycle valid -> txd per 4 clk is 0,1,0,1,0,1,0,1,0,1. tx_ready returns 1 at cycle 40 after accept.
//  3. Back-to-back: valid held high with 0xA5 then 0x3C -> second accept occurs exactly 1 idle cycle after stop. Decoded bytes are A5, 3C.
//  4. Busy ignore: pulse valid with 0xFF mid-frame of 0x00 -> only 0x00 is sent, and no second frame follows.
//  5. Reset mid-frame: resetn=0 at data bit 3 of 0x0F -> txd=1 on the next edge. After release, 0x81 sends cleanly.
//  6. UART_TX_PARITY_EN, PARITY_ODD=0: 0x07 -> parity bit 1, 0x03 -> parity bit 0. Frame is 44 clk.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line constants, the FSM state type and the
// clocks-per-bit divider. uart_tx uses this package, and a future uart_rx will too.
package uart_pkg;

    localparam int   UART_DATA_W   = 8;
    localparam logic UART_IDLE_LVL = 1'b1;

    // PARITY is listed even when parity is compiled out, so that tx and rx
    // share a single state encoding.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int uart_div(input int clk_freq_hz, input int baud);
        return (clk_freq_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter. It counts 0..DIV-1 and pulses tick on the last cycle of
// each bit. restart holds the count at zero, so every frame starts on a fresh
// bit boundary.
module uart_baud_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // tick is a decode of the registered count, so it stays glitch-free
    // relative to clk.
    assign tick = (count_q == CNT_W'(DIV - 1));

    // Next count: wrap at the end of each bit and hold at zero while restarting.
    always_comb begin
        // NOTE: assign a default before any branch in always_comb; a path that
        // leaves a variable unassigned infers a latch.
        count_d = count_q + 1'b1;
        if (restart || tick) begin
            count_d = '0;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before the edge.
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter. It accepts one byte per valid/ready handshake
// and sends it LSB first as 8N1, idle high.
// Build option: define UART_TX_PARITY_EN to insert a parity bit (8E1, or 8O1
// with PARITY_ODD=1) between the data and stop bits.
import uart_pkg::*;

module uart_tx #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 9600,
    parameter int PARITY_ODD  = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx_busy,
    output logic                   txd
);

    localparam int DIV = uart_div(CLK_FREQ_HZ, BAUD);

    // Reject configurations that cannot hold each bit for DIV cycles.
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx: DIV must be >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    uart_state_e            state_q,   state_d;
    logic [UART_DATA_W-1:0] shreg_q,   shreg_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   txd_q,     txd_d;
    logic                   ready_q,   ready_d;
    logic                   busy_q,    busy_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q,  parity_d;
`endif

    logic accept;
    logic tick;

    assign accept = tx_valid && ready_q;

    // The counter is held at zero while idle. Accept therefore starts the
    // start bit on a full period, and natural wraps mark every later boundary.
    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk     (clk),
        .resetn  (resetn),
        .restart (state_q == IDLE),
        .tick    (tick)
    );

    // Next-state logic. Each output is decided one cycle early so that it can
    // be driven straight from a flop.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        txd_d     = txd_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    shreg_d   = tx_data;
                    bit_idx_d = '0;
                    txd_d     = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d  = (^tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    txd_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = parity_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    txd_d   = UART_IDLE_LVL;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = UART_IDLE_LVL;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers. A reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        // NOTE: the shift register is reset along with the control state. It
        // is only eight flops, and resetting it keeps its contents defined.
        if (!resetn) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= UART_IDLE_LVL;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign txd      = txd_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLK_FREQ_HZ=16, BAUD=4 (four clocks per bit).
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_uart_tx;

    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC     = NBITS * DIV;
    localparam logic PARITY_ODD_TB = 1'b0;

    logic       clk;
    logic       resetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       txd;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx #(
        .CLK_FREQ_HZ (16),
        .BAUD        (4),
        .PARITY_ODD  (0)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .txd      (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level for frame bit idx: start, 8 data bits LSB first,
    // optional parity, stop.
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return (^b) ^ PARITY_ODD_TB;
`endif
        return 1'b1;
    endfunction

    // Called just after the accept edge. It checks every cycle of the frame,
    // decodes the data bits at mid-bit, and checks the idle cycle that follows.
    // tx_valid becomes valid_after after cycle 0. At cycle 10, tx_valid and
    // tx_data are set to mid_valid and mid_data; with mid_pulse set, tx_valid
    // returns to valid_after at cycle 11.
    task automatic run_frame(input logic [7:0] b, input string tag,
                             input logic valid_after, input logic mid_valid,
                             input logic [7:0] mid_data, input logic mid_pulse);
        logic [7:0] dec;
        logic       exp;
        dec = 8'h00;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            exp = exp_bit(b, i / DIV);
            n_cmp++;
            if (txd !== exp || tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s cycle %0d: txd=%b busy=%b ready=%b, required txd=%b busy=1 ready=0",
                         tag, i, txd, tx_busy, tx_ready, exp);
            end
            if ((i % DIV) == DIV / 2 && (i / DIV) >= 1 && (i / DIV) <= 8)
                dec[(i / DIV) - 1] = txd;
            if (i == 0) tx_valid = valid_after;
            if (i == 10) begin
                tx_valid = mid_valid;
                tx_data  = mid_data;
            end
            if (i == 11 && mid_pulse) tx_valid = valid_after;
        end
        n_cmp++;
        if (dec !== b) begin
            n_bad++;
            $display("FAIL %s decode: got %h, required %h", tag, dec, b);
        end
        @(negedge clk);
        n_cmp++;
        if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s end: txd=%b ready=%b busy=%b, required 1 1 0",
                     tag, txd, tx_ready, tx_busy);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold %0d: txd=%b ready=%b busy=%b, required 1 1 0",
                         i, txd, tx_ready, tx_busy);
            end
        end
        resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_release %0d: txd=%b ready=%b busy=%b, required 1 1 0",
                         i, txd, tx_ready, tx_busy);
            end
        end
    endtask

    task automatic test_single();
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(posedge clk);
        // The mid-frame data change must not affect the frame being sent.
        run_frame(8'h55, "single_55", 1'b0, 1'b0, 8'hAA, 1'b0);
    endtask

    task automatic test_back_to_back();
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk);
        run_frame(8'hA5, "b2b_first", 1'b1, 1'b1, 8'h3C, 1'b0);
        // One idle cycle has just been checked; the next edge must accept 3C.
        @(posedge clk);
        run_frame(8'h3C, "b2b_second", 1'b0, 1'b0, 8'h3C, 1'b0);
    endtask

    task automatic test_busy_ignore();
        logic bad;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        run_frame(8'h00, "busy_ignore", 1'b0, 1'b1, 8'hFF, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_ignore_idle: line left idle=%b, required 0", bad);
        end
    endtask

    task automatic test_reset_midframe();
        tx_data  = 8'h0F;
        tx_valid = 1'b1;
        @(posedge clk);
        // Data bit 3 occupies cycles 16..19.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 0) tx_valid = 1'b0;
        end
        n_cmp++;
        if (txd !== 1'b1 || tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midframe_bit3: txd=%b busy=%b ready=%b, required 1 1 0",
                     txd, tx_busy, tx_ready);
        end
        resetn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midframe_abort: txd=%b ready=%b busy=%b, required 1 1 0",
                     txd, tx_ready, tx_busy);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midframe_release: txd=%b ready=%b busy=%b, required 1 1 0",
                     txd, tx_ready, tx_busy);
        end
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        @(posedge clk);
        run_frame(8'h81, "after_reset_81", 1'b0, 1'b0, 8'h81, 1'b0);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        @(posedge clk);
        run_frame(8'h07, "parity_07", 1'b0, 1'b0, 8'h07, 1'b0);
        tx_data  = 8'h03;
        tx_valid = 1'b1;
        @(posedge clk);
        run_frame(8'h03, "parity_03", 1'b0, 1'b0, 8'h03, 1'b0);
    endtask
`endif

    initial begin
        resetn   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_ignore();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
